// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller sequencing the program counter.
// Walks BOOT -> FETCH -> DECODE, keeps one instruction in flight, hands the
// instruction register to decode over a valid/ready handshake and redirects
// the PC on taken branches.
// Optional feature macro: IRQ_EN (interrupt entry with epc capture and
// edge re-arm). Without it irq is ignored and irq_ack/epc stay 0.
module fetch_sequencer #(
    parameter int                    data_width   = 16,
    parameter logic [data_width-1:0] RESET_VECTOR = '0,
    parameter logic [data_width-1:0] IRQ_VECTOR   = data_width'(4)
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [data_width-1:0] pc,
    output logic                  pc_up,
    output logic                  pc_load,
    output logic [data_width-1:0] pc_data,
    output logic                  mem_req,
    output logic [data_width-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [data_width-1:0] mem_rdata,
    output logic [data_width-1:0] ir,
    output logic                  ir_valid,
    input  logic                  ir_ready,
    input  logic                  stall,
    input  logic                  br_take,
    input  logic [data_width-1:0] br_target,
    input  logic                  irq,
    output logic                  irq_ack,
    output logic [data_width-1:0] epc
);

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        DECODE = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [data_width-1:0] ir_q, ir_d;
    logic [data_width-1:0] epc_q, epc_d;
    logic                  handshake;
    logic                  irq_take;

    assign mem_addr  = pc;
    assign ir        = ir_q;
    assign epc       = epc_q;
    assign handshake = (state_q == DECODE) && ir_ready && !stall;

`ifdef IRQ_EN
    logic armed_q, armed_d;

    // An interrupt is taken only on a non-branch handshake while armed.
    assign irq_take = handshake && !br_take && irq && armed_q;

    // Re-arm once irq is observed low at a handshake; disarm on entry so a
    // level that stays high does not re-enter the handler.
    always_comb begin
        armed_d = armed_q;
        if (irq_take) begin
            armed_d = 1'b0;
        end else if (handshake && !irq) begin
            armed_d = 1'b1;
        end
    end

    // Interrupt arm flag register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            armed_q <= 1'b1;
        end else begin
            armed_q <= armed_d;
        end
    end
`else
    logic unused_irq;

    assign unused_irq = irq;
    assign irq_take   = 1'b0;
`endif

    // Next-state and strobe decode from the registered state and live inputs.
    always_comb begin
        // NOTE: every output and next-state value gets a default first so no
        // path through the case leaves one unassigned (which would infer a latch).
        state_d  = state_q;
        ir_d     = ir_q;
        epc_d    = epc_q;
        pc_up    = 1'b0;
        pc_load  = 1'b0;
        pc_data  = '0;
        mem_req  = 1'b0;
        ir_valid = 1'b0;
        irq_ack  = 1'b0;

        unique case (state_q)
            BOOT: begin
                // The state register sits in BOOT throughout reset, so the
                // reset-vector load is qualified by clr to keep strobes quiet.
                if (clr) begin
                    pc_load = 1'b1;
                    pc_data = RESET_VECTOR;
                end
                state_d = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_d    = mem_rdata;
                    pc_up   = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ir_valid = 1'b1;
                if (handshake) begin
                    state_d = FETCH;
                    if (br_take) begin
                        pc_load = 1'b1;
                        pc_data = br_target;
                    end else if (irq_take) begin
                        pc_load = 1'b1;
                        pc_data = IRQ_VECTOR;
                        irq_ack = 1'b1;
                        epc_d   = pc;
                    end
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // State, instruction register and return-address registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= BOOT;
            // NOTE: ir and epc are visible on ports, so they are reset like
            // control state rather than left as unreset datapath storage.
            ir_q    <= '0;
            epc_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q <= state_d;
            ir_q    <= ir_d;
            epc_q   <= epc_d;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed-plus-random bench for fetch_sequencer.
// Models the program counter and instruction memory around the DUT and keeps
// an instruction-level reference (expected fetch address, epc, arm flag).
module tb_fetch_sequencer;

    localparam int          DW = 16;
    localparam logic [15:0] RV = 16'h0000;
    localparam logic [15:0] IV = 16'h0004;
`ifdef IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          clr;
    logic [DW-1:0] pc;
    logic          pc_up, pc_load;
    logic [DW-1:0] pc_data;
    logic          mem_req;
    logic [DW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] ir;
    logic          ir_valid;
    logic          ir_ready, stall, br_take;
    logic [DW-1:0] br_target;
    logic          irq, irq_ack;
    logic [DW-1:0] epc;

    int tests = 0;
    int fails = 0;

    // Reference state at instruction granularity.
    logic [15:0] exp_addr;
    logic [15:0] exp_epc;
    bit          armed;

    fetch_sequencer #(
        .data_width  (DW),
        .RESET_VECTOR(RV),
        .IRQ_VECTOR  (IV)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .pc       (pc),
        .pc_up    (pc_up),
        .pc_load  (pc_load),
        .pc_data  (pc_data),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .ir       (ir),
        .ir_valid (ir_valid),
        .ir_ready (ir_ready),
        .stall    (stall),
        .br_take  (br_take),
        .br_target(br_target),
        .irq      (irq),
        .irq_ack  (irq_ack),
        .epc      (epc)
    );

    always #5 clk = ~clk;

    // Program counter driven by the DUT strobes, cleared by the shared clr.
    always @(posedge clk or negedge clr) begin
        if (!clr)         pc <= '0;
        else if (pc_load) pc <= pc_data;
        else if (pc_up)   pc <= pc + 16'd1;
    end

    function automatic logic [15:0] word_at(input logic [15:0] a);
        return a ^ 16'hA5C3;
    endfunction

    // Instruction memory contents are a fixed function of the address.
    assign mem_rdata = word_at(mem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // FETCH phase: the request is held until the ack arrives after 'delay' cycles.
    task automatic do_fetch(input int delay);
        for (int d = 0; d <= delay; d++) begin
            mem_ack   = (d == delay);
            ir_ready  = 1'($urandom);
            stall     = 1'($urandom);
            br_take   = 1'($urandom);
            irq       = 1'($urandom);
            br_target = 16'($urandom);
            @(negedge clk);
            check("fetch_req",   {31'd0, mem_req}, 32'd1);
            check("fetch_addr",  {16'd0, mem_addr}, {16'd0, exp_addr});
            check("fetch_up",    {31'd0, pc_up}, (d == delay) ? 32'd1 : 32'd0);
            check("fetch_load",  {31'd0, pc_load}, 32'd0);
            check("fetch_valid", {31'd0, ir_valid}, 32'd0);
            check("fetch_irqack",{31'd0, irq_ack}, 32'd0);
            check("epc",         {16'd0, epc}, {16'd0, exp_epc});
            next_cycle();
        end
        mem_ack = 1'b0;
    endtask

    // DECODE phase: 'waits' blocked cycles, then a handshake with the given
    // branch/interrupt inputs.
    task automatic do_decode(input int waits, input bit br, input logic [15:0] tgt, input bit irq_v);
        bit take_irq;
        for (int w = 0; w < waits; w++) begin
            if ($urandom_range(0, 1) == 0) begin
                stall    = 1'b1;
                ir_ready = 1'($urandom);
            end else begin
                stall    = 1'b0;
                ir_ready = 1'b0;
            end
            mem_ack   = 1'($urandom);
            br_take   = 1'($urandom);
            irq       = 1'($urandom);
            br_target = 16'($urandom);
            @(negedge clk);
            check("hold_valid", {31'd0, ir_valid}, 32'd1);
            check("hold_req",   {31'd0, mem_req}, 32'd0);
            check("hold_ir",    {16'd0, ir}, {16'd0, word_at(exp_addr)});
            check("hold_up",    {31'd0, pc_up}, 32'd0);
            check("hold_load",  {31'd0, pc_load}, 32'd0);
            check("hold_irqack",{31'd0, irq_ack}, 32'd0);
            next_cycle();
        end
        ir_ready  = 1'b1;
        stall     = 1'b0;
        br_take   = br;
        br_target = tgt;
        irq       = irq_v;
        mem_ack   = 1'($urandom);
        take_irq  = IRQ_ON && !br && irq_v && armed;
        @(negedge clk);
        check("hs_valid",  {31'd0, ir_valid}, 32'd1);
        check("hs_ir",     {16'd0, ir}, {16'd0, word_at(exp_addr)});
        check("hs_req",    {31'd0, mem_req}, 32'd0);
        check("hs_up",     {31'd0, pc_up}, 32'd0);
        check("hs_load",   {31'd0, pc_load}, (br || take_irq) ? 32'd1 : 32'd0);
        check("hs_irqack", {31'd0, irq_ack}, take_irq ? 32'd1 : 32'd0);
        if (br || take_irq)
            check("hs_pcdata", {16'd0, pc_data}, {16'd0, (br ? tgt : IV)});
        if (!irq_v) armed = 1'b1;
        if (take_irq) begin
            armed   = 1'b0;
            exp_epc = exp_addr + 16'd1;
        end
        exp_addr = br ? tgt : (take_irq ? IV : exp_addr + 16'd1);
        next_cycle();
        br_take = 1'b0;
        irq     = 1'b0;
    endtask

    task automatic instr(input int delay, input int waits, input bit br,
                         input logic [15:0] tgt, input bit irq_v);
        do_fetch(delay);
        do_decode(waits, br, tgt, irq_v);
    endtask

    task automatic check_boot();
        @(negedge clk);
        check("boot_load",   {31'd0, pc_load}, 32'd1);
        check("boot_pcdata", {16'd0, pc_data}, {16'd0, RV});
        check("boot_req",    {31'd0, mem_req}, 32'd0);
        check("boot_up",     {31'd0, pc_up}, 32'd0);
        check("boot_valid",  {31'd0, ir_valid}, 32'd0);
        next_cycle();
    endtask

    initial begin
        clr = 1'b1; mem_ack = 1'b0; ir_ready = 1'b0; stall = 1'b0;
        br_take = 1'b0; br_target = '0; irq = 1'b0;
        #2 clr = 1'b0;
        exp_addr = RV; exp_epc = '0; armed = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_up",     {31'd0, pc_up}, 32'd0);
        check("rst_load",   {31'd0, pc_load}, 32'd0);
        check("rst_pcdata", {16'd0, pc_data}, 32'd0);
        check("rst_req",    {31'd0, mem_req}, 32'd0);
        check("rst_valid",  {31'd0, ir_valid}, 32'd0);
        check("rst_irqack", {31'd0, irq_ack}, 32'd0);
        check("rst_ir",     {16'd0, ir}, 32'd0);
        check("rst_epc",    {16'd0, epc}, 32'd0);
        @(posedge clk); #1;
        clr = 1'b1;
        check_boot();

        // Linear fetch at 0..3, then branch to 0x0010 from 4.
        for (int i = 0; i < 4; i++) instr(0, 0, 1'b0, 16'h0, 1'b0);
        instr(0, 0, 1'b1, 16'h0010, 1'b0);
        // Slow memory at 0x0010.
        instr(3, 0, 1'b0, 16'h0, 1'b0);
        // Five blocked decode cycles at 0x0011.
        instr(0, 5, 1'b0, 16'h0, 1'b0);
        // Branch to 0x0100, then to 0x0020.
        instr(0, 0, 1'b1, 16'h0100, 1'b0);
        instr(1, 1, 1'b1, 16'h0020, 1'b0);
        // Interrupt at 0x0020, re-arm, then irq with branch, then irq alone.
        instr(0, 0, 1'b0, 16'h0, 1'b1);
        instr(0, 0, 1'b0, 16'h0, 1'b0);
        instr(0, 0, 1'b1, 16'h0030, 1'b1);
        instr(0, 0, 1'b0, 16'h0, 1'b1);
        instr(0, 0, 1'b0, 16'h0, 1'b1);
        instr(0, 0, 1'b0, 16'h0, 1'b0);
        // Address wrap: fetch at 0xFFFF is followed by a fetch at 0.
        instr(0, 0, 1'b1, 16'hFFFF, 1'b0);
        instr(0, 0, 1'b0, 16'h0, 1'b0);
        instr(0, 0, 1'b0, 16'h0, 1'b0);

        // Randomized instruction stream.
        for (int i = 0; i < 150; i++) begin
            instr($urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 3) == 0), 16'($urandom),
                  ($urandom_range(0, 2) == 0));
        end

        // Reset pulsed during FETCH with mem_ack high.
        mem_ack = 1'b1;
        #2 clr = 1'b0;
        #1;
        check("mid_ir",     {16'd0, ir}, 32'd0);
        check("mid_valid",  {31'd0, ir_valid}, 32'd0);
        check("mid_req",    {31'd0, mem_req}, 32'd0);
        check("mid_up",     {31'd0, pc_up}, 32'd0);
        check("mid_epc",    {16'd0, epc}, 32'd0);
        check("mid_irqack", {31'd0, irq_ack}, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        clr = 1'b1;
        exp_addr = RV; exp_epc = '0; armed = 1'b1;
        check_boot();
        instr(0, 0, 1'b0, 16'h0, 1'b0);
        instr(2, 1, 1'b0, 16'h0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the RISC core that sequences the program counter. It drives the PC's increment/load/data inputs, issues one instruction-memory read per instruction, and holds the fetched word in an instruction register. It hands that word to decode through a valid/ready handshake and redirects the PC on taken branches and, optionally, on interrupts. It sits between the program counter, instruction memory and the decode stage; exactly one instruction is in flight at a time.

## Interface
- data_width, 16, width of PC, addresses and instruction words
- RESET_VECTOR, 16'h0000, first fetch address after reset
- IRQ_VECTOR, 16'h0004, handler address loaded on interrupt entry (used only with IRQ_EN)

- clk  in  1  rising-edge clock
- clr  in  1  reset, asynchronous, active-low; also drives the program counter's clr
- pc  in  data_width  current program counter value
- pc_up  out  1  PC increment strobe
- pc_load  out  1  PC load strobe
- pc_data  out  data_width  PC load value
- mem_req  out  1  instruction read request
- mem_addr  out  data_width  read address; equals pc
- mem_ack  in  1  read data valid this cycle
- mem_rdata  in  data_width  instruction word
- ir  out  data_width  instruction register
- ir_valid  out  1  ir holds an unconsumed instruction
- ir_ready  in  1  decode accepts ir
- stall  in  1  pipeline hold; blocks the decode handshake
- br_take  in  1  taken branch/jump, sampled only on handshake
- br_target  in  data_width  branch destination
- irq  in  1  level interrupt request
- irq_ack  out  1  one-cycle interrupt acceptance pulse
- epc  out  data_width  return address captured on interrupt entry

## Operation
- State machine: BOOT, FETCH, DECODE. The state is registered; all strobes decode combinationally from state and inputs.
- Reset (clr=0, asynchronous):
  - State goes to BOOT.
  - ir=0 and epc=0.
  - pc_up, pc_load, pc_data, mem_req, ir_valid and irq_ack are all 0.
- BOOT:
  - Lasts one cycle after clr deasserts.
  - pc_load=1 and pc_data=RESET_VECTOR.
  - Next state is FETCH.
- FETCH:
  - mem_req=1 and mem_addr=pc.
  - The bench holds the request until mem_ack=1.
  - In the mem_ack cycle: ir<=mem_rdata and pc_up=1 (the PC advances to pc+1 at the same edge). Next state is DECODE.
- DECODE:
  - ir_valid=1 and mem_req=0.
  - Handshake fires when ir_ready=1 and stall=0. Without a handshake, the block holds with ir stable.
  - On handshake with br_take=1: pc_load=1, pc_data=br_target, then FETCH.
  - On handshake with br_take=0 and an accepted interrupt (see Configuration): pc_load=1, pc_data=IRQ_VECTOR, irq_ack=1, epc<=pc (the sequential return address), then FETCH.
  - On handshake otherwise: go to FETCH with no PC strobe.
- Priority:
  - A branch beats an interrupt. A pending irq is deferred to the next handshake.
  - pc_load and pc_up are never asserted together.
- mem_ack outside FETCH is ignored. br_take and irq outside a handshake are ignored.
- Address arithmetic is modulo 2^data_width; a fetch at all-ones is followed by a fetch at 0.

## Timing
- Reset release to first mem_req: 1 cycle (BOOT).
- Minimum instruction period: 2 cycles (FETCH with immediate ack, then DECODE with immediate handshake).
- The redirect is visible on mem_addr in the cycle after the handshake.
- ir_valid rises the cycle after mem_ack and falls the cycle after the handshake.
- irq_ack lasts exactly one cycle, coincident with its pc_load.
- clr asserted mid-fetch or mid-decode: outputs go to reset values immediately, and any pending mem_ack is discarded.

## Configuration
- IRQ_EN defined:
  - irq is sampled at the DECODE handshake as described in Operation.
  - The block vectors to IRQ_VECTOR, pulses irq_ack and captures epc.
  - No new interrupt is accepted until irq is seen low at a later handshake (edge re-arm); this prevents re-entry while the level stays high.
- IRQ_EN undefined:
  - irq is ignored, and irq_ack and epc are tied to 0.
  - Ports remain present; IRQ_VECTOR is unused.

## Test plan
- Reset then linear fetch: release clr with memory acking immediately, ir_ready=1 -> pc_load with pc_data=0 in BOOT, fetches at 0,1,2,3, one instruction every 2 cycles.
- Slow memory: mem_ack delayed 3 cycles at address 0x0010 -> mem_req held 4 cycles with mem_addr stable at 0x0010, single pc_up.
- Stall: stall=1 for 5 cycles in DECODE -> ir and ir_valid stable, no PC strobe, no mem_req, then resume.
- Branch: handshake with br_take=1, br_target=0x0100 -> pc_load=1, next mem_addr=0x0100.
- Interrupt (IRQ_EN): irq=1 at handshake of instruction at 0x0020, br_take=0 -> pc_load to 0x0004, irq_ack one cycle, epc=0x0021. With irq and br_take together -> branch taken, irq taken at the next handshake.
- Reset mid-operation: clr pulsed low during FETCH with mem_ack=1 -> ir=0 and ir_valid=0 immediately; after release, BOOT reloads RESET_VECTOR.
